seq_dtr: RTL and testbench

//  Judge for the "precision button press" game. An external sweeper drives a one-hot LED pattern;
//  the player picks a target position on SW and presses BTN. On each press, the block compares the
//  LED position against the target and raises Z on a hit.
//  It also keeps an 8-deep hit/miss history (SEQ) and a saturating hit counter (SEQ2) for the display.

---
 rtl/seq_dtr_pkg.sv | 14 +
 rtl/seq_dtr_if.sv | 34 +++
 rtl/seq_dtr_btn.sv | 76 +++++++
 rtl/seq_dtr.sv | 81 ++++++++
 tb/tb_seq_dtr.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/seq_dtr_pkg.sv
// seq_dtr shared types and defaults.
// Imported by the interface, the button front end and the top.
package seq_dtr_pkg;

    typedef enum logic [1:0] {
        ARMED,
        HIT,
        MISS
    } state_t;

    localparam int W_DEF  = 8;
    localparam int DB_DEF = 4;

endpackage

// File: rtl/seq_dtr_if.sv
// Player/sweeper/display bundle for the seq_dtr judge.
// master drives BTN/LEDS/SW; slave (the judge) drives Z/SEQ/SEQ2.
interface seq_dtr_if
    import seq_dtr_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         BTN;
    logic [W-1:0] LEDS;
    logic [W-1:0] SW;
    logic         Z;
    logic [W-1:0] SEQ;
    logic [W-1:0] SEQ2;

    modport master (
        output BTN,
        output LEDS,
        output SW,
        input  Z,
        input  SEQ,
        input  SEQ2
    );

    modport slave (
        input  BTN,
        input  LEDS,
        input  SW,
        output Z,
        output SEQ,
        output SEQ2
    );

endinterface

// File: rtl/seq_dtr_btn.sv
// Button front end: sync, optional debounce, rising-edge press pulse.
// SEQ_DTR_DEBOUNCE_EN selects the DB_CYC-cycle debounce filter.
module seq_dtr_btn
    import seq_dtr_pkg::*;
`ifdef SEQ_DTR_DEBOUNCE_EN
#(
    parameter int DB_CYC = DB_DEF
)
`endif
(
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic press
);

    logic init_q, init_d;
    logic btn_d_q, btn_d_d;
    logic btn_s;
    logic sync_q, sync_d;

`ifdef SEQ_DTR_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYC + 1);

    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = BTN;
        lvl_d  = lvl_q;
        cnt_d  = '0;
        if (init_q) begin
            lvl_d = BTN;
        end else if (sync_q != lvl_q) begin
            if (cnt_q == CW'(DB_CYC - 1)) lvl_d = ~lvl_q;
            else                          cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign btn_s = lvl_q;
`else
    assign sync_d = BTN;
    assign btn_s  = sync_q;
`endif

    // First edge after reset loads btn_d from BTN so a held button is not a press
    always_comb begin
        init_d  = 1'b0;
        btn_d_d = init_q ? BTN : btn_s;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_q  <= 1'b1;
            sync_q  <= 1'b0;
            btn_d_q <= 1'b1;
        end else begin
            init_q  <= init_d;
            sync_q  <= sync_d;
            btn_d_q <= btn_d_d;
        end
    end

    assign press = btn_s & ~btn_d_q;

endmodule

// File: rtl/seq_dtr.sv
// Precision-press judge: hit FSM, outcome history and saturating hit count.
// Build with SEQ_DTR_DEBOUNCE_EN to debounce BTN over DB_CYC cycles.
module seq_dtr
    import seq_dtr_pkg::*;
#(
    parameter int W = W_DEF
`ifdef SEQ_DTR_DEBOUNCE_EN
    ,
    parameter int DB_CYC = DB_DEF
`endif
) (
    input  logic      CLK,
    input  logic      RST_N,
    seq_dtr_if.slave  io
);

    logic         press;
    logic         hit;
    state_t       state_q, state_d;
    logic         z_q, z_d;
    logic [W-1:0] seq_q, seq_d;
    logic [W-1:0] seq2_q, seq2_d;

`ifdef SEQ_DTR_DEBOUNCE_EN
    seq_dtr_btn #(
        .DB_CYC (DB_CYC)
    ) u_btn (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (io.BTN),
        .press (press)
    );
`else
    seq_dtr_btn u_btn (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (io.BTN),
        .press (press)
    );
`endif

    assign hit = |(io.LEDS & io.SW);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        seq2_d  = seq2_q;
        unique case (1'b1)
            press & hit: begin
                state_d = HIT;
                seq_d   = {seq_q[W-2:0], 1'b1};
                if (~&seq2_q) seq2_d = seq2_q + 1'b1;
            end
            press & ~hit: begin
                state_d = MISS;
                seq_d   = {seq_q[W-2:0], 1'b0};
            end
            default: ;
        endcase
        z_d = (state_d == HIT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARMED;
            z_q     <= 1'b0;
            seq_q   <= '0;
            seq2_q  <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            seq_q   <= seq_d;
            seq2_q  <= seq2_d;
        end
    end

    assign io.Z    = z_q;
    assign io.SEQ  = seq_q;
    assign io.SEQ2 = seq2_q;

endmodule

// File: tb/tb_seq_dtr.sv
// Bench for seq_dtr: outcome-list model checked every cycle
// plus directed game scenarios with literal expectations.
module tb_seq_dtr;

    logic CLK;
    logic RST_N;

    seq_dtr_if #(.W(8)) io ();

    seq_dtr #(.W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .io    (io)
    );

    int checks = 0;
    int errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: list of judged outcomes since reset
    bit   hist[$];
    bit   prev_btn;
    bit   pend;
    int   hits;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist.delete();
            prev_btn = 1'b1;
            pend     = 1'b0;
            hits     = 0;
        end else begin
            if (pend) begin
                hist.push_back((io.LEDS & io.SW) != 8'h00);
                if ((io.LEDS & io.SW) != 8'h00) hits++;
                pend = 1'b0;
            end
            if (io.BTN && !prev_btn) pend = 1'b1;
            prev_btn = io.BTN;
        end
    end

    function automatic logic [7:0] m_seq();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8 && i < hist.size(); i++)
            r[i] = hist[hist.size() - 1 - i];
        return r;
    endfunction

    function automatic logic [7:0] m_cnt();
        return (hits > 255) ? 8'hFF : 8'(hits);
    endfunction

    function automatic logic m_z();
        return (hist.size() > 0) && hist[hist.size() - 1];
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("cyc_Z", {7'd0, io.Z}, {7'd0, m_z()});
        check("cyc_SEQ", io.SEQ, m_seq());
        check("cyc_SEQ2", io.SEQ2, m_cnt());
    end

    task automatic lit(input string tag, input logic z, input logic [7:0] s,
                       input logic [7:0] c);
        #1;
        check({tag, "_Z"}, {7'd0, io.Z}, {7'd0, z});
        check({tag, "_SEQ"}, io.SEQ, s);
        check({tag, "_SEQ2"}, io.SEQ2, c);
    endtask

    task automatic sweep(input logic [7:0] at);
        logic [7:0] pat = 8'h80;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            io.LEDS = pat;
            io.BTN  = (pat == at);
            pat     = pat >> 1;
        end
        @(negedge CLK);
        io.BTN = 1'b0;
    endtask

    task automatic press_on(input logic [7:0] leds, input logic [7:0] sw);
        @(negedge CLK);
        io.LEDS = leds;
        io.SW   = sw;
        io.BTN  = 1'b1;
        @(negedge CLK);
        io.BTN  = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RST_N   = 1'b0;
        io.BTN  = 1'b0;
        io.LEDS = 8'h00;
        io.SW   = 8'h00;
        #3;
        lit("reset", 1'b0, 8'h00, 8'h00);
        #8 RST_N = 1'b1;

        // 1: press on 20, judged on 10 -> hit
        io.SW = 8'h10;
        sweep(8'h20);
        lit("t1", 1'b1, 8'h01, 8'h01);

        // 2: press on 08, judged on 04 -> miss
        sweep(8'h08);
        lit("t2", 1'b0, 8'h02, 8'h01);

        // 3: held button, matching LEDS recurs -> one judgement
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            io.LEDS = (i % 2) ? 8'h10 : 8'h20;
            io.BTN  = 1'b1;
        end
        @(negedge CLK);
        io.BTN = 1'b0;
        @(negedge CLK);
        lit("t3", 1'b1, 8'h05, 8'h02);

        // 5: SW=0 always misses; multi-hot overlap hits
        press_on(8'hFF, 8'h00);
        lit("t5a", 1'b0, 8'h0A, 8'h02);
        press_on(8'h30, 8'h10);
        lit("t5b", 1'b1, 8'h15, 8'h03);

        // 4: saturation
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            io.LEDS = 8'h01;
            io.SW   = 8'h01;
            io.BTN  = 1'b1;
            @(negedge CLK);
            io.BTN  = 1'b0;
        end
        @(negedge CLK);
        lit("t4", 1'b1, 8'hFF, 8'hFF);

        // 6: async reset mid-game, button held through release
        @(posedge CLK);
        #2;
        io.BTN = 1'b1;
        RST_N  = 1'b0;
        lit("t6_async", 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        lit("t6_held", 1'b0, 8'h00, 8'h00);
        @(negedge CLK);
        io.BTN = 1'b0;
        press_on(8'h01, 8'h01);
        lit("t6_after", 1'b1, 8'h01, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
